bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-port bus arbiter and transfer sequencer sitting between the CPU core and the external bus (RAM/IO). It accepts word-wide load/store requests from the CPU port (port 0) and a DMA/video port (port 1). It grants one request at a time and runs the four-phase o_bus_clk / i_bus_data_ready handshake for it. It then returns read data, an acknowledge and a timeout error to the granted requester.

## Interface
Parameters:
- ADDR_W, 32, bus address width (matches the CPU `VW width)
- DATA_W, 32, bus data width
- CPU_PRIORITY, 0, 1 = port 0 always wins a tie; 0 = round-robin on ties
- TIMEOUT, 255, maximum cycles in STROBE or RELEASE before abort; 0 disables the timeout

Ports:
- i_clk  in  1  system clock; all logic on the rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_req  in  2  per-port request; held high with its fields stable until that port's o_ack
- i_we  in  2  per-port write enable (1 = store)
- i_addr0 / i_addr1  in  ADDR_W  per-port address
- i_wdata0 / i_wdata1  in  DATA_W  per-port write data
- o_ack  out  2  one-cycle pulse per port on transfer completion or abort
- o_err  out  1  valid with o_ack; 1 = transfer aborted by timeout
- o_rdata  out  DATA_W  read data; valid with o_ack on a read; held until the next ack
- o_grant  out  2  one-hot owner of the current transfer; 0 in IDLE
- o_bus_clk  out  1  bus strobe
- o_bus_we  out  1  bus write enable
- o_bus_addr  out  ADDR_W  bus address
- o_bus_data  out  DATA_W  bus write data
- i_bus_data  in  DATA_W  bus read data
- i_bus_data_ready  in  1  bus target acknowledge

## Operation
The sequencer has three states: IDLE, STROBE and RELEASE.
- **IDLE**
  - Entered on reset and after each transfer.
  - If any i_req bit is set: choose the winner, set o_grant, and latch that port's we/addr/wdata into o_bus_we/o_bus_addr/o_bus_data. Then set o_bus_clk <= 1 and go to STROBE.
  - If i_bus_data_ready is still high from a previous transfer, stay in IDLE and do not start.
- **Arbitration**
  - A single requester wins.
  - On a tie with CPU_PRIORITY=1, port 0 wins.
  - On a tie with CPU_PRIORITY=0, the port not granted last wins. The last-grant pointer resets to port 1, so port 0 wins the first tie.
  - The pointer updates when a transfer completes or aborts.
- **STROBE**
  - o_bus_clk = 1.
  - When i_bus_data_ready = 1 is sampled:
    - If the transfer is a read, latch i_bus_data into o_rdata.
    - Pulse o_ack[grant] with o_err = 0.
    - Set o_bus_clk <= 0 and go to RELEASE.
- **RELEASE**
  - o_bus_clk = 0.
  - When i_bus_data_ready = 0 is sampled, clear o_grant and go to IDLE.
  - o_bus_addr, o_bus_data and o_bus_we hold their values through RELEASE.
- **Timeout**
  - One counter, cleared on every state entry and incremented each cycle in STROBE or RELEASE.
  - In STROBE, at count == TIMEOUT:
    - Pulse o_ack[grant] with o_err = 1.
    - Leave o_rdata unchanged.
    - Set o_bus_clk <= 0 and go to RELEASE.
  - In RELEASE, at count == TIMEOUT: go to IDLE unconditionally. No extra ack is issued.
- **Request dropped mid-transfer:** ignored; the transfer runs to completion and the ack is still issued.
- **Reset**
  - Reset during any state forces IDLE on the next edge; the in-flight transfer is dropped with no ack.
  - Reset values: o_bus_clk=0, o_bus_we=0, o_bus_addr=0, o_bus_data=0, o_ack=0, o_err=0, o_rdata=0, o_grant=0, counter=0.

## Timing
All outputs are registered. For a read with zero target wait states:
- Cycle 0: IDLE samples i_req.
- Cycle 1: o_bus_clk=1; the target raises i_bus_data_ready.
- Cycle 2: o_ack and o_rdata valid; o_bus_clk=0; the target drops i_bus_data_ready.
- Cycle 3: IDLE.

Throughput and latency:
- Minimum cost is 3 cycles per transfer.
- Back-to-back requests start every 3 cycles.
- A second requester waits at most one full transfer plus timeout under round-robin.
- Each wait cycle of the target adds one cycle in STROBE.
- The ack-to-release gap is 0 cycles: the ack pulse and o_bus_clk falling are on the same edge.

## Structure
- Shared package `bus_pkg`:
  - state enum: IDLE / STROBE / RELEASE
  - port index constants: PORT_CPU=0, PORT_DMA=1
- Natural sub-module: `rr_arbiter2`, combinational winner selection plus the registered last-grant pointer.
- Expected implementation size is about 150–250 lines total.

## Test plan
- **Single read:** port 0 reads addr 0x0000_1234; target returns 0xA5 with zero wait → o_bus_clk high exactly 1 cycle, o_ack=01 at cycle 2, o_rdata=0x0000_00A5, o_err=0.
- **Write with waits:** port 1 writes 0xDEAD_BEEF to 0x0000_8000; ready delayed 4 cycles → o_bus_we=1 and addr/data stable the whole transfer, o_ack=10 in the cycle after ready is seen.
- **Tie arbitration:**
  - CPU_PRIORITY=0, both ports request continuously → grants alternate 01, 10, 01, 10, starting with port 0.
  - CPU_PRIORITY=1, same stimulus → port 0 always granted while it requests.
- **Timeout:** TIMEOUT=8, ready never asserted → o_ack with o_err=1 exactly 8 cycles after STROBE entry, o_rdata unchanged, return to IDLE after the RELEASE timeout.
- **Stuck-ready:** ready held high after a transfer → no new strobe until ready falls; the next transfer starts on the first IDLE cycle after ready falls.
- **Reset mid-transfer:** i_rst_n=0 during STROBE → next edge o_bus_clk=0, o_grant=0, no ack; a subsequent request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-port bus arbiter.
//   state_e  : transfer sequencer states (idle, strobe high, strobe released)
//   PORT_CPU : request port index of the CPU core
//   PORT_DMA : request port index of the DMA/video engine
package bus_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStrobe  = 2'd1,
        StRelease = 2'd2
    } state_e;

    // One-bit indices so they select directly into the 2-bit per-port vectors.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester winner selection with a registered last-grant pointer.
//   clk, rst_n : clock and synchronous active-low reset
//   req        : per-port request vector
//   update     : pulse when the current transfer completes or aborts
//   done_port  : index of the port whose transfer just ended (valid with update)
//   grant      : combinational one-hot winner, 0 when nobody requests
module rr_arbiter2
    import bus_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       done_port,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = done_port;
        end
    end

    // Pointer starts at the DMA port so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= PORT_DMA;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01: grant[PORT_CPU] = 1'b1;
            2'b10: grant[PORT_DMA] = 1'b1;
            2'b11: begin
                if ((CPU_PRIORITY != 0) || (last_q == PORT_DMA)) begin
                    grant[PORT_CPU] = 1'b1;
                end else begin
                    grant[PORT_DMA] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter and four-phase strobe/ready transfer sequencer.
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_req, i_we             : per-port request and write enable
//   i_addr0/1, i_wdata0/1   : per-port address and write data
//   o_ack, o_err            : per-port completion pulse; err marks a timeout abort
//   o_rdata                 : read data, held until the next read completes
//   o_grant                 : one-hot owner of the transfer in flight
//   o_bus_clk, o_bus_we     : bus strobe and write enable
//   o_bus_addr, o_bus_data  : bus address and write data
//   i_bus_data              : bus read data
//   i_bus_data_ready        : target acknowledge
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CPU_PRIORITY = 0,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_ack,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_grant,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready
);

    // The counter only has to reach TIMEOUT-1 before the state is left.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic               bus_clk_q, bus_clk_d;
    logic               bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_data_q, bus_data_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         ack_q, ack_d;
    logic               err_q, err_d;

    logic [1:0]         win;
    logic               arb_update;
    logic               tmo_hit;

    rr_arbiter2 #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_rr_arbiter2 (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req       (i_req),
        .update    (arb_update),
        .done_port (grant_q[PORT_DMA]),
        .grant     (win)
    );

    // cnt_q counts completed cycles in the state, so the current cycle is the
    // TIMEOUT-th one when cnt_q == TIMEOUT-1; the strobe is then high for
    // exactly TIMEOUT cycles before the abort ack.
    assign tmo_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        bus_clk_d  = bus_clk_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        rdata_d    = rdata_q;
        ack_d      = 2'b00;
        err_d      = 1'b0;
        arb_update = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A target still holding ready from the last transfer blocks a new strobe.
                if ((i_req != 2'b00) && !i_bus_data_ready) begin
                    state_d   = StStrobe;
                    cnt_d     = '0;
                    grant_d   = win;
                    bus_clk_d = 1'b1;
                    if (win[PORT_DMA]) begin
                        bus_we_d   = i_we[PORT_DMA];
                        bus_addr_d = i_addr1;
                        bus_data_d = i_wdata1;
                    end else begin
                        bus_we_d   = i_we[PORT_CPU];
                        bus_addr_d = i_addr0;
                        bus_data_d = i_wdata0;
                    end
                end
            end

            StStrobe: begin
                // Ready wins over a timeout landing on the same cycle.
                if (i_bus_data_ready || tmo_hit) begin
                    if (i_bus_data_ready && !bus_we_q) begin
                        rdata_d = i_bus_data;
                    end
                    ack_d      = grant_q;
                    err_d      = !i_bus_data_ready;
                    bus_clk_d  = 1'b0;
                    state_d    = StRelease;
                    cnt_d      = '0;
                    arb_update = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StRelease: begin
                if (!i_bus_data_ready || tmo_hit) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = StIdle;
                grant_d   = 2'b00;
                bus_clk_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            rdata_q    <= '0;
            ack_q      <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            bus_clk_q  <= bus_clk_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_err      = err_q;
    assign o_rdata    = rdata_q;
    assign o_grant    = grant_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter. Two instances run side by side: g=0 uses
// round-robin ties, g=1 gives the CPU port priority; both use TIMEOUT=8.
// Each instance has its own requesters, bus target and reference model.
module tb_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Traffic knobs, percentages per cycle or per transfer.
    int unsigned req_pct   = 30;
    int unsigned keep_pct  = 0;
    int unsigned long_pct  = 0;
    int unsigned stuck_pct = 0;
    int unsigned rst_pct   = 0;

    int n_ties[2];
    int n_tmo[2];
    int n_rel_tmo[2];
    int dut_acks[2];
    int model_acks[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic          rst_n;
        logic [1:0]    req, we, ack, grant;
        logic [AW-1:0] addr0, addr1, bus_addr;
        logic [DW-1:0] wdata0, wdata1, rdata, bus_wdata, bus_rdata;
        logic          err, bus_clk, bus_we, ready;

        bus_arbiter #(
            .ADDR_W       (AW),
            .DATA_W       (DW),
            .CPU_PRIORITY (g),
            .TIMEOUT      (TO)
        ) u_dut (
            .i_clk            (clk),
            .i_rst_n          (rst_n),
            .i_req            (req),
            .i_we             (we),
            .i_addr0          (addr0),
            .i_addr1          (addr1),
            .i_wdata0         (wdata0),
            .i_wdata1         (wdata1),
            .o_ack            (ack),
            .o_err            (err),
            .o_rdata          (rdata),
            .o_grant          (grant),
            .o_bus_clk        (bus_clk),
            .o_bus_we         (bus_we),
            .o_bus_addr       (bus_addr),
            .o_bus_data       (bus_wdata),
            .i_bus_data       (bus_rdata),
            .i_bus_data_ready (ready)
        );

        // Model: a transfer is either absent, strobing or releasing; n counts
        // the cycles spent in the current half, including the present one.
        bit            busy, strobing;
        int            n, owner, last;
        logic [1:0]    m_ack, m_grant;
        logic          m_err, m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata;

        // Target and reset bookkeeping.
        int   wait_left, hold_left, rst_hold;
        logic clk_seen;
        bit   fresh;
        string nm;

        initial begin
            nm = (g == 0) ? "rr" : "pri";
            rst_n = 1'b0; rst_hold = 3;
            req = 2'b00; we = 2'b00;
            addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
            ready = 1'b0; bus_rdata = '0;
            busy = 0; strobing = 0; n = 0; owner = 0; last = 1;
            m_ack = 2'b00; m_grant = 2'b00; m_err = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            wait_left = 0; hold_left = 0; clk_seen = 1'b0;

            forever begin
                @(negedge clk);

                // Advance the model by the rising edge just taken.
                m_ack = 2'b00;
                m_err = 1'b0;
                if (!rst_n) begin
                    busy = 0; strobing = 0; n = 0; last = 1;
                    m_grant = 2'b00; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
                end else if (!busy) begin
                    if (req != 2'b00 && !ready) begin
                        if (req == 2'b11) begin
                            n_ties[g]++;
                            owner = (g == 1) ? 0 : ((last == 1) ? 0 : 1);
                        end else begin
                            owner = req[1] ? 1 : 0;
                        end
                        m_grant  = (owner == 0) ? 2'b01 : 2'b10;
                        m_we     = we[owner];
                        m_addr   = (owner == 0) ? addr0 : addr1;
                        m_wdata  = (owner == 0) ? wdata0 : wdata1;
                        busy     = 1;
                        strobing = 1;
                        n        = 0;
                    end
                end else if (strobing) begin
                    n++;
                    if (ready || n == TO) begin
                        m_ack = m_grant;
                        m_err = !ready;
                        if (ready && !m_we) m_rdata = bus_rdata;
                        if (!ready) n_tmo[g]++;
                        last     = owner;
                        strobing = 0;
                        n        = 0;
                    end
                end else begin
                    n++;
                    if (!ready || n == TO) begin
                        if (ready) n_rel_tmo[g]++;
                        busy    = 0;
                        m_grant = 2'b00;
                        n       = 0;
                    end
                end

                check($sformatf("%s.grant", nm), 64'(grant), 64'(m_grant));
                check($sformatf("%s.ack", nm), 64'(ack), 64'(m_ack));
                check($sformatf("%s.err", nm), 64'(err), 64'(m_err));
                check($sformatf("%s.bus_clk", nm), 64'(bus_clk), 64'(busy && strobing));
                check($sformatf("%s.bus_we", nm), 64'(bus_we), 64'(m_we));
                check($sformatf("%s.bus_addr", nm), 64'(bus_addr), 64'(m_addr));
                check($sformatf("%s.bus_data", nm), 64'(bus_wdata), 64'(m_wdata));
                check($sformatf("%s.rdata", nm), 64'(rdata), 64'(m_rdata));
                if (ack != 2'b00) dut_acks[g]++;
                if (m_ack != 2'b00) model_acks[g]++;

                // Reset: initial pulse, then occasional random pulses.
                if (rst_hold > 0) begin
                    rst_n = 1'b0;
                    rst_hold--;
                end else begin
                    rst_n = ($urandom_range(99) < rst_pct) ? 1'b0 : 1'b1;
                end

                // Bus target: answer the strobe after a random wait, then drop
                // ready a random time after the strobe falls.
                if (!rst_n) begin
                    ready = 1'b0;
                end else if (bus_clk) begin
                    if (!clk_seen) begin
                        wait_left = ($urandom_range(99) < long_pct) ?
                                    int'($urandom_range(14, 6)) : int'($urandom_range(3, 0));
                    end
                    if (!ready) begin
                        if (wait_left == 0) begin
                            ready     = 1'b1;
                            bus_rdata = $urandom;
                            hold_left = ($urandom_range(99) < stuck_pct) ?
                                        int'($urandom_range(12, 6)) : int'($urandom_range(2, 0));
                        end else begin
                            wait_left--;
                        end
                    end
                end else if (ready) begin
                    if (hold_left == 0) ready = 1'b0;
                    else hold_left--;
                end
                clk_seen = bus_clk;

                // Requesters hold each request with stable fields until acked.
                for (int p = 0; p < 2; p++) begin
                    fresh = 0;
                    if (req[p] && ack[p]) begin
                        req[p] = ($urandom_range(99) < keep_pct);
                        fresh  = req[p];
                    end else if (!req[p] && ($urandom_range(99) < req_pct)) begin
                        req[p] = 1'b1;
                        fresh  = 1;
                    end
                    if (fresh) begin
                        we[p] = 1'($urandom_range(1));
                        if (p == 0) begin
                            addr0  = $urandom;
                            wdata0 = $urandom;
                        end else begin
                            addr1  = $urandom;
                            wdata1 = $urandom;
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Sparse mixed traffic with a fast target.
        req_pct = 30; keep_pct = 0; long_pct = 5; stuck_pct = 5; rst_pct = 0;
        repeat (600) @(negedge clk);
        // Both ports requesting back to back: every start is a tie.
        req_pct = 100; keep_pct = 100; long_pct = 0; stuck_pct = 0;
        repeat (600) @(negedge clk);
        // Slow targets: strobe timeouts and ready stuck high past release.
        req_pct = 50; keep_pct = 50; long_pct = 40; stuck_pct = 40;
        repeat (800) @(negedge clk);
        // Random resets landing in every phase of a transfer.
        rst_pct = 3; long_pct = 20; stuck_pct = 20;
        repeat (800) @(negedge clk);
        rst_pct = 0;
        repeat (5) @(negedge clk);
        #1;

        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst%0d.ack_count", g), 64'(dut_acks[g]), 64'(model_acks[g]));
            check($sformatf("inst%0d.ties_seen", g), 64'(n_ties[g] > 20), 64'(1));
            check($sformatf("inst%0d.timeouts_seen", g), 64'(n_tmo[g] > 0), 64'(1));
            check($sformatf("inst%0d.release_timeouts_seen", g), 64'(n_rel_tmo[g] > 0), 64'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
